// File: rtl/up_sampler.sv
// ---------------------------------------------------------------------------
// up_sampler
//   2x nearest-neighbour up-sampler. It drains a down-sampled pixel FIFO with
//   first-word-not-fall-through timing, so read data and in_valid arrive one
//   cycle after in_rd_en. Each pixel is emitted on two consecutive transfers.
//   Each input row is emitted twice: first from the FIFO, then replayed from
//   an internal line buffer.
//
//   Optional feature (macro UP_SAMPLER_EOL_EN): adds an eol output. eol is
//   high together with valid on the last transfer of every output row.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   in_empty  in   FIFO empty flag
//   in_rd_en  out  FIFO read strobe
//   in_dout   in   FIFO read data, qualified by in_valid
//   in_valid  in   FIFO read-data valid, one cycle after in_rd_en
//   dout      out  output pixel (head of the pixel queue)
//   valid     out  output pixel valid
//   ready     in   downstream accept; a transfer is valid && ready
//   eol       out  end of output row (only with UP_SAMPLER_EOL_EN)
// ---------------------------------------------------------------------------
module up_sampler #(
    parameter int DATA_W   = 8,
    parameter int IN_WIDTH = 800,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_empty,
    output logic              in_rd_en,
    input  logic [DATA_W-1:0] in_dout,
    input  logic              in_valid,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              ready
`ifdef UP_SAMPLER_EOL_EN
    ,
    output logic              eol
`endif
);

    typedef enum logic [0:0] {
        FETCH_FIFO = 1'b0,
        FETCH_LINE = 1'b1
    } fetch_state_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IN_WIDTH - 1);

    // Fetch side
    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [ADDR_W-1:0] fcol_r;
    logic [ADDR_W-1:0] fcol_nxt_s;
    logic              rd_fifo_s;
    logic              rd_line_s;

    // Outstanding reads: FIFO reads awaiting in_valid, line read awaiting data
    logic [1:0]        fifo_pend_r;
    logic              lb_pend_r;
    logic [2:0]        occupancy_s;
    logic              slot_free_s;

    // Line buffer
    logic [DATA_W-1:0] lb_mem [IN_WIDTH];
    logic [DATA_W-1:0] lb_rd_data_r;
    logic [ADDR_W-1:0] wcol_r;

    // Two-entry pixel queue; q0_r is the head and drives dout directly
    logic [DATA_W-1:0] q0_r;
    logic [DATA_W-1:0] q1_r;
    logic [1:0]        q_cnt_r;
    logic [1:0]        q_cnt_nxt_s;
    logic              valid_r;
    logic              dup_r;

    logic              fifo_ret_s;
    logic              push_s;
    logic [DATA_W-1:0] push_data_s;
    logic              xfer_s;
    logic              pop_s;

    // Queue source/sink strobes and free-slot test
    always_comb begin
        // A stray in_valid with no FIFO read pending is ignored
        fifo_ret_s  = in_valid && (fifo_pend_r != 2'd0);
        push_s      = fifo_ret_s || lb_pend_r;
        push_data_s = fifo_ret_s ? in_dout : lb_rd_data_r;
        xfer_s      = valid_r && ready;
        pop_s       = xfer_s && dup_r;
        // Reads in flight reserve a slot, so a push can never overflow
        occupancy_s = {1'b0, q_cnt_r} + {1'b0, fifo_pend_r} + {2'b00, lb_pend_r};
        slot_free_s = (occupancy_s < 3'd2);
        if (push_s && !pop_s) begin
            q_cnt_nxt_s = q_cnt_r + 2'd1;
        end else if (pop_s && !push_s) begin
            q_cnt_nxt_s = q_cnt_r - 2'd1;
        end else begin
            q_cnt_nxt_s = q_cnt_r;
        end
    end

    // Fetch FSM next-state and read issue
    always_comb begin
        state_nxt_s = state_r;
        fcol_nxt_s  = fcol_r;
        rd_fifo_s   = 1'b0;
        rd_line_s   = 1'b0;
        case (state_r)
            FETCH_FIFO: begin
                // rst gating keeps in_rd_en low during reset
                if (!rst && !in_empty && slot_free_s) begin
                    rd_fifo_s = 1'b1;
                    if (fcol_r == LAST_COL) begin
                        fcol_nxt_s  = '0;
                        state_nxt_s = FETCH_LINE;
                    end else begin
                        fcol_nxt_s = fcol_r + ADDR_W'(1);
                    end
                end else begin
                    rd_fifo_s = 1'b0;
                end
            end
            FETCH_LINE: begin
                if (!rst && slot_free_s) begin
                    rd_line_s = 1'b1;
                    if (fcol_r == LAST_COL) begin
                        fcol_nxt_s  = '0;
                        state_nxt_s = FETCH_FIFO;
                    end else begin
                        fcol_nxt_s = fcol_r + ADDR_W'(1);
                    end
                end else begin
                    rd_line_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = FETCH_FIFO;
                fcol_nxt_s  = '0;
            end
        endcase
    end

    assign in_rd_en = rd_fifo_s;

    // Fetch state, column and outstanding-read bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FETCH_FIFO;
            fcol_r      <= '0;
            fifo_pend_r <= 2'd0;
            lb_pend_r   <= 1'b0;
            wcol_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            fcol_r      <= fcol_nxt_s;
            fifo_pend_r <= fifo_pend_r + {1'b0, rd_fifo_s} - {1'b0, fifo_ret_s};
            // A line read always returns on the next cycle
            lb_pend_r   <= rd_line_s;
            if (fifo_ret_s) begin
                wcol_r <= (wcol_r == LAST_COL) ? '0 : wcol_r + ADDR_W'(1);
            end
        end
    end

    // Line buffer storage: write returned FIFO pixels, synchronous replay read
    always_ff @(posedge clk) begin
        if (fifo_ret_s) begin
            lb_mem[wcol_r] <= in_dout;
        end
        if (rd_line_s) begin
            lb_rd_data_r <= lb_mem[fcol_r];
        end
    end

    // Pixel queue and output duplication state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0_r    <= '0;
            q1_r    <= '0;
            q_cnt_r <= 2'd0;
            valid_r <= 1'b0;
            dup_r   <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (q_cnt_r == 2'd0) begin
                        q0_r <= push_data_s;
                    end else begin
                        q1_r <= push_data_s;
                    end
                end
                2'b01: begin
                    q0_r <= q1_r;
                end
                2'b11: begin
                    if (q_cnt_r == 2'd2) begin
                        q0_r <= q1_r;
                        q1_r <= push_data_s;
                    end else begin
                        q0_r <= push_data_s;
                    end
                end
                default: begin
                    q0_r <= q0_r;
                end
            endcase
            q_cnt_r <= q_cnt_nxt_s;
            valid_r <= (q_cnt_nxt_s != 2'd0);
            if (xfer_s) begin
                dup_r <= ~dup_r;
            end
        end
    end

    assign dout  = q0_r;
    assign valid = valid_r;

`ifdef UP_SAMPLER_EOL_EN
    localparam logic [ADDR_W:0] LAST_OCOL = (ADDR_W + 1)'(2 * IN_WIDTH - 1);

    logic [ADDR_W:0] ocol_r;

    // Output column counter, advanced only by transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ocol_r <= '0;
        end else if (xfer_s) begin
            ocol_r <= (ocol_r == LAST_OCOL) ? '0 : ocol_r + (ADDR_W + 1)'(1);
        end
    end

    assign eol = valid_r && (ocol_r == LAST_OCOL);
`endif

endmodule

// File: tb/tb_up_sampler.sv
// ---------------------------------------------------------------------------
// tb_up_sampler
//   Directed sequence of scenarios with randomized pixels and ready, checked
//   against a reference that expands each complete input row into its
//   2x-horizontal, 2x-vertical output sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_up_sampler;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          in_empty;
    logic          in_rd_en;
    logic [DW-1:0] in_dout;
    logic          in_valid;
    logic [DW-1:0] dout;
    logic          valid;
    logic          ready;
`ifdef UP_SAMPLER_EOL_EN
    logic          eol;
`endif

    up_sampler #(.DATA_W(DW), .IN_WIDTH(N), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .in_dout  (in_dout),
        .in_valid (in_valid),
        .dout     (dout),
        .valid    (valid),
        .ready    (ready)
`ifdef UP_SAMPLER_EOL_EN
        ,
        .eol      (eol)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_q  [$];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] row_buf [$];

    int       rd_cnt    = 0;
    int       xfer_cnt  = 0;
    int       gaps      = 0;
    bit       seen_first = 1'b0;
    bit       pace_en   = 1'b0;
    int       pace_cnt  = 0;
    bit       rand_rdy  = 1'b0;
    bit       hold_pending = 1'b0;
    logic [DW-1:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a completed row yields each pixel twice, and the whole row twice
    task automatic push_pixel(input logic [DW-1:0] p);
        fifo_q.push_back(p);
        row_buf.push_back(p);
        if (row_buf.size() == N) begin
            for (int r = 0; r < 2; r++) begin
                foreach (row_buf[i]) begin
                    exp_q.push_back(row_buf[i]);
                    exp_q.push_back(row_buf[i]);
                end
            end
            row_buf.delete();
        end
    endtask

    // FWFT-less FIFO model: data and in_valid one cycle after a read
    initial begin
        logic rd_s;
        logic emp_s;
        forever begin
            @(negedge clk);
            rd_s  = in_rd_en;
            emp_s = in_empty;
            if (rd_s) check("rd_while_empty", emp_s, 1'b0);
            @(posedge clk);
            #1;
            if (!rst && rd_s && !emp_s && fifo_q.size() != 0) begin
                in_dout  = fifo_q.pop_front();
                in_valid = 1'b1;
                rd_cnt++;
                pace_cnt = pace_en ? 4 : 0;
            end else begin
                in_valid = 1'b0;
                if (pace_cnt != 0) pace_cnt--;
            end
            in_empty = (fifo_q.size() == 0) || (pace_cnt != 0);
        end
    end

    // Output monitor: ordering, hold-while-stalled, gaps, eol
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
                xfer_cnt     = 0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", valid, 1'b1);
                    check("hold_dout", dout, held);
                end
                if (valid) seen_first = 1'b1;
                if (!valid && seen_first && exp_q.size() != 0) gaps++;
`ifdef UP_SAMPLER_EOL_EN
                if (!valid) check("eol_idle", eol, 1'b0);
`endif
                if (valid && ready) begin
                    check("expected_output_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("dout", dout, e);
                    end
`ifdef UP_SAMPLER_EOL_EN
                    check("eol", eol, (xfer_cnt % (2 * N)) == (2 * N - 1));
`endif
                    xfer_cnt++;
                    hold_pending = 1'b0;
                end else if (valid) begin
                    hold_pending = 1'b1;
                    held = dout;
                end else begin
                    hold_pending = 1'b0;
                end
            end
        end
    end

    // Clock until the reference sequence is consumed or the budget expires
    task automatic run_drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            cyc++;
        end
        ready = 1'b1;
        check({tag, "_drained"}, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, valid, 1'b0);
    endtask

    task automatic start_test;
        rd_cnt     = 0;
        gaps       = 0;
        seen_first = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;
        rst      = 1'b1;
        ready    = 1'b0;
        in_valid = 1'b0;
        in_dout  = '0;
        in_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid, 1'b0);
        check("reset_rd_en", in_rd_en, 1'b0);
        check("reset_dout", dout, 8'd0);
`ifdef UP_SAMPLER_EOL_EN
        check("reset_eol", eol, 1'b0);
`endif
        rst = 1'b0;

        // A: preloaded 1..8, ready high
        start_test();
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_pixel(DW'(i));
        run_drain("basic", 200);
        check("basic_rd_count", rd_cnt, 8);
        check("basic_gaps", gaps, 0);

        // B: random pixels, random ready
        start_test();
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) push_pixel(DW'($urandom_range(0, 255)));
        run_drain("stall", 600);
        rand_rdy = 1'b0;
        check("stall_rd_count", rd_cnt, 12);

        // C: FIFO delivers one pixel every 5 cycles
        start_test();
        pace_en = 1'b1;
        for (int i = 0; i < 8; i++) push_pixel(DW'($urandom_range(0, 255)));
        run_drain("paced", 600);
        pace_en = 1'b0;
        check("paced_rd_count", rd_cnt, 8);
        check("paced_has_gaps", gaps > 0, 1'b1);

        // D: reset after output 6 of a row, then a fresh row 9..12
        start_test();
        base = xfer_cnt;
        for (int i = 1; i <= 4; i++) push_pixel(DW'(i));
        cyc = 0;
        while ((xfer_cnt - base) < 6 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midrow_reached", (xfer_cnt - base) >= 6, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrow_rst_valid", valid, 1'b0);
        check("midrow_rst_rd_en", in_rd_en, 1'b0);
        @(negedge clk);
        fifo_q.delete();
        exp_q.delete();
        row_buf.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_test();
        for (int i = 9; i <= 12; i++) push_pixel(DW'(i));
        run_drain("after_rst", 200);
        check("after_rst_rd_count", rd_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
